ambient_light_filter: RTL and testbench



---
 rtl/ambient_light_filter.sv | 139 +++++++++++++
 tb/tb_ambient_light_filter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ambient_light_filter.sv
// Day/night level conditioner for ambient-light ADC samples: threshold hysteresis plus consecutive-sample debounce.
// Optional AMBIENT_AVG_EN macro compares a 4-sample running average instead of the raw sample.
module ambient_light_filter #(
    parameter int unsigned ADC_W      = 10,
    parameter int unsigned DARK_THR   = 300,
    parameter int unsigned BRIGHT_THR = 400,
    parameter int unsigned HOLD_CNT   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             adc_valid,
    input  logic [ADC_W-1:0] adc_data,
    output logic             light_sensor,
    output logic             change_pulse,
    output logic [1:0]       state_dbg
);

    localparam int unsigned CNT_W = $clog2(HOLD_CNT + 1);

    typedef enum logic [1:0] {
        DAY      = 2'b00,
        TO_NIGHT = 2'b01,
        NIGHT    = 2'b10,
        TO_DAY   = 2'b11
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic [CNT_W-1:0] count_inc;
    logic             light_nxt;
    logic             pulse_nxt;
    logic [ADC_W-1:0] sample;
    logic             judge;
    logic             dark;
    logic             bright;
    logic             hit;

`ifdef AMBIENT_AVG_EN
    localparam int unsigned SUM_W = ADC_W + 2;

    logic [ADC_W-1:0] s0;
    logic [ADC_W-1:0] s1;
    logic [ADC_W-1:0] s2;
    logic [1:0]       fill;
    logic [SUM_W-1:0] sum;

    assign sum    = SUM_W'(s0) + SUM_W'(s1) + SUM_W'(s2) + SUM_W'(adc_data);
    assign sample = sum[SUM_W-1:2];
    // The first three valid samples only prime the history.
    assign judge  = adc_valid && (fill == 2'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s0   <= '0;
            s1   <= '0;
            s2   <= '0;
            fill <= 2'd0;
        end else if (adc_valid) begin
            s2 <= s1;
            s1 <= s0;
            s0 <= adc_data;
            if (fill != 2'd3) begin
                fill <= fill + 2'd1;
            end
        end
    end
`else
    assign sample = adc_data;
    assign judge  = adc_valid;
`endif

    assign dark      = sample < ADC_W'(DARK_THR);
    assign bright    = sample > ADC_W'(BRIGHT_THR);
    assign count_inc = (count == CNT_W'(HOLD_CNT)) ? count : count + CNT_W'(1);
    assign hit       = (count_inc == CNT_W'(HOLD_CNT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= DAY;
            count        <= '0;
            light_sensor <= 1'b0;
            change_pulse <= 1'b0;
        end else begin
            state        <= state_nxt;
            count        <= count_nxt;
            light_sensor <= light_nxt;
            change_pulse <= pulse_nxt;
        end
    end

    assign state_dbg = state;

    // Settled states hold count at 0, so count_inc==1 there and HOLD_CNT==1 switches directly.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        light_nxt = light_sensor;
        pulse_nxt = 1'b0;
        if (judge) begin
            case (state)
                DAY, TO_NIGHT: begin
                    if (!dark) begin
                        state_nxt = DAY;
                        count_nxt = '0;
                    end else if (hit) begin
                        state_nxt = NIGHT;
                        count_nxt = '0;
                        light_nxt = 1'b1;
                        pulse_nxt = 1'b1;
                    end else begin
                        state_nxt = TO_NIGHT;
                        count_nxt = count_inc;
                    end
                end
                NIGHT, TO_DAY: begin
                    if (!bright) begin
                        state_nxt = NIGHT;
                        count_nxt = '0;
                    end else if (hit) begin
                        state_nxt = DAY;
                        count_nxt = '0;
                        light_nxt = 1'b0;
                        pulse_nxt = 1'b1;
                    end else begin
                        state_nxt = TO_DAY;
                        count_nxt = count_inc;
                    end
                end
                default: begin
                    state_nxt = DAY;
                    count_nxt = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ambient_light_filter.sv
// Self-checking bench for ambient_light_filter: directed scenarios plus random samples,
// compared against a run-length model of the day/night level.
module tb_ambient_light_filter;

    localparam int unsigned ADC_W      = 10;
    localparam int unsigned DARK_THR   = 300;
    localparam int unsigned BRIGHT_THR = 400;
    localparam int unsigned HOLD_CNT   = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             adc_valid;
    logic [ADC_W-1:0] adc_data;
    logic             light_sensor;
    logic             change_pulse;
    logic [1:0]       state_dbg;

    ambient_light_filter #(
        .ADC_W(ADC_W), .DARK_THR(DARK_THR), .BRIGHT_THR(BRIGHT_THR), .HOLD_CNT(HOLD_CNT)
    ) dut (
        .clk(clk), .reset(reset), .adc_valid(adc_valid), .adc_data(adc_data),
        .light_sensor(light_sensor), .change_pulse(change_pulse), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Reference: level plus length of the current run of samples that argue for the other level.
    bit m_level;
    int m_run;
    bit m_pulse;
    int hist[$];

    task automatic model_reset();
        m_level = 1'b0;
        m_run   = 0;
        m_pulse = 1'b0;
        hist.delete();
    endtask

    task automatic model_step(input bit valid, input int data);
        int  v;
        bit  q;
        m_pulse = 1'b0;
        if (!valid) return;
`ifdef AMBIENT_AVG_EN
        if (hist.size() < 3) begin
            hist.push_back(data);
            return;
        end
        v = ((hist[0] + hist[1] + hist[2] + data) / 4) % (1 << ADC_W);
        void'(hist.pop_front());
        hist.push_back(data);
`else
        v = data;
`endif
        q = m_level ? (v > int'(BRIGHT_THR)) : (v < int'(DARK_THR));
        if (q) begin
            m_run++;
            if (m_run == int'(HOLD_CNT)) begin
                m_level = ~m_level;
                m_run   = 0;
                m_pulse = 1'b1;
            end
        end else begin
            m_run = 0;
        end
    endtask

    task automatic check(input string tag);
        logic [1:0] exp_state;
        exp_state = {m_level, (m_run != 0)};
        checks++;
        assert (light_sensor === m_level) passes++;
        else $error("FAIL %s light_sensor got %b exp %b", tag, light_sensor, m_level);
        checks++;
        assert (change_pulse === m_pulse) passes++;
        else $error("FAIL %s change_pulse got %b exp %b", tag, change_pulse, m_pulse);
        checks++;
        assert (state_dbg === exp_state) passes++;
        else $error("FAIL %s state_dbg got %b exp %b", tag, state_dbg, exp_state);
    endtask

    task automatic step(input bit valid, input int data, input string tag);
        @(negedge clk);
        adc_valid = valid;
        adc_data  = ADC_W'(data);
        @(posedge clk);
        #1;
        model_step(valid, data);
        check(tag);
    endtask

    task automatic repeat_sample(input int data, input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b1, data, tag);
    endtask

    task automatic mid_reset(input string tag);
        @(negedge clk);
        reset     = 1'b1;
        adc_valid = 1'b0;
        #1;
        model_reset();
        check(tag);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        int r;
        reset     = 1'b1;
        adc_valid = 1'b0;
        adc_data  = '0;
        model_reset();
        #1;
        check("reset_pre_edge");
        #2;
        reset = 1'b0;

`ifdef AMBIENT_AVG_EN
        // Averaged mode: history primes first; 200,200,200,600 averages to 300, not dark.
        repeat_sample(200, 3, "avg_prime");
        step(1'b1, 600, "avg_boundary");
        repeat_sample(100, 4, "avg_dark");
        mid_reset("avg_reset");
`endif

        repeat_sample(250, HOLD_CNT, "to_night");
        repeat_sample(450, HOLD_CNT, "to_day");

        repeat_sample(250, 3, "abort_pend");
        step(1'b1, 350, "abort_mid");
        repeat_sample(300, 5, "dark_boundary");

        repeat_sample(250, HOLD_CNT, "night_again");
        repeat_sample(350, 10, "night_mid");
        repeat_sample(450, HOLD_CNT, "to_day_2");
        repeat_sample(250, HOLD_CNT, "night_3");
        repeat_sample(400, HOLD_CNT, "bright_boundary");
        repeat_sample(450, HOLD_CNT, "to_day_3");

        for (int i = 0; i < 4; i++) begin
            step(1'b1, 250, "idle_gap_valid");
            for (int k = 0; k < i; k++) step(1'b0, 250, "idle_gap_hold");
        end
        repeat_sample(450, HOLD_CNT, "back_day");

        repeat_sample(250, 2, "pre_reset");
        mid_reset("mid_reset");
        repeat_sample(250, 3, "post_reset");
        repeat_sample(450, 1, "post_reset_abort");

        for (int i = 0; i < 500; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 4)       r = int'($urandom_range(0, 299));
            else if (r == 4) r = (($urandom_range(0, 1)) != 0) ? 300 : 400;
            else if (r == 5) r = int'($urandom_range(300, 400));
            else             r = int'($urandom_range(401, 1023));
            step($urandom_range(0, 3) != 0, r, "random");
            if (i == 250) mid_reset("random_reset");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
